// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit: processes DIGIT bits per clock, LSB digit first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
    logic             sub_q, chain_q, chain_d;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] slice;
    logic             c, ai, bi;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             a_msb_q, b_msb_q;
`endif

    // One digit of full-adder / full-subtractor cells, seeded by the registered chain bit.
    always_comb begin
        c     = chain_q;
        ai    = 1'b0;
        bi    = 1'b0;
        slice = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            ai       = a_q[i];
            bi       = b_q[i];
            slice[i] = ai ^ bi ^ c;
            if (sub_q) begin
                c = (~ai & bi) | (~(ai ^ bi) & c);
            end else begin
                c = (ai & bi) | ((ai ^ bi) & c);
            end
        end
        chain_d = c;
        acc_d   = (acc_q >> DIGIT) | (WIDTH'(slice) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sub_q   <= 1'b0;
            chain_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf     <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRun;
                        busy    <= 1'b1;
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        chain_q <= cin;
                        cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    acc_q   <= acc_d;
                    chain_q <= chain_d;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= acc_d;
                        cout    <= chain_d;
`ifdef SERIAL_ADDSUB_OVF_EN
                        // add needs equal operand signs, sub needs differing ones
                        ovf <= ((a_msb_q ^ b_msb_q) == sub_q) &&
                               (acc_d[WIDTH-1] != a_msb_q);
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized self-checking bench for serial_addsub; three instances cover N = 8, 4 and 1.
// An arithmetic reference model supplies every expected result, carry/borrow and overflow.
module tb_serial_addsub;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sub, cin;
    logic [15:0] a, b;
    int          sel;

    logic        start0, start1, start2;
    logic        busy0, done0, cout0, ovf0;
    logic        busy1, done1, cout1, ovf1;
    logic        busy2, done2, cout2, ovf2;
    logic [7:0]  res0, res2;
    logic [15:0] res1;

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign start2 = start && (sel == 2);

`ifndef SERIAL_ADDSUB_OVF_EN
    assign ovf0 = 1'b0;
    assign ovf1 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy0), .done(done0), .result(res0), .cout(cout0)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf0)
`endif
    );

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .result(res1), .cout(cout1)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_addsub #(.WIDTH(8), .DIGIT(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy2), .done(done2), .result(res2), .cout(cout2)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf2)
`endif
    );

    logic        m_busy, m_done, m_cout, m_ovf;
    logic [15:0] m_res;
    always_comb begin
        m_busy = busy0; m_done = done0; m_cout = cout0; m_ovf = ovf0; m_res = {8'h00, res0};
        if (sel == 1) begin
            m_busy = busy1; m_done = done1; m_cout = cout1; m_ovf = ovf1; m_res = res1;
        end else if (sel == 2) begin
            m_busy = busy2; m_done = done2; m_cout = cout2; m_ovf = ovf2; m_res = {8'h00, res2};
        end
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_res;
    logic        exp_cout, exp_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 1) ? 16 : 8;
    endfunction

    function automatic int digits_of(input int s);
        return (s == 0) ? 8 : ((s == 1) ? 4 : 1);
    endfunction

    // Plain integer arithmetic: true sum/difference, then wrap, carry/borrow and signed range.
    function automatic void model(input int w, input logic s, input longint av, input longint bv,
                                  input logic ci, output logic [15:0] r, output logic co,
                                  output logic ov);
        longint m, half, sa, sb, cv, t;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        cv   = ci ? 1 : 0;
        sa   = (av >= half) ? av - (m + 1) : av;
        sb   = (bv >= half) ? bv - (m + 1) : bv;
        if (!s) begin
            t  = av + bv + cv;
            co = (t > m);
            r  = 16'(t & m);
            t  = sa + sb + cv;
        end else begin
            t  = av - bv - cv;
            co = (av < bv + cv);
            r  = 16'(t & m);
            t  = sa - sb - cv;
        end
        ov = (t >= half) || (t < -half);
    endfunction

    // Applies start at the current negedge (back-to-back if the DUT sits in DONE).
    task automatic run_op(input int s_sel, input logic s, input logic [15:0] av,
                          input logic [15:0] bv, input logic ci, input bit disturb,
                          input string tag);
        int n, cyc, bcnt;
        n   = digits_of(s_sel);
        sel = s_sel; sub = s; a = av; b = bv; cin = ci; start = 1'b1;
        model(width_of(s_sel), s, longint'(av), longint'(bv), ci, exp_res, exp_cout, exp_ovf);
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        bcnt  = 0;
        while (!m_done && cyc < 100) begin
            if (m_busy) bcnt++;
            if (disturb && cyc == 1) begin
                a = ~av; b = 16'($urandom); sub = ~s; cin = ~ci; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, cyc, n);
        check({tag, " busy_cycles"}, bcnt, n);
        check({tag, " busy_at_done"}, m_busy, 1'b0);
        check({tag, " result"}, m_res, exp_res);
        check({tag, " cout"}, m_cout, exp_cout);
`ifdef SERIAL_ADDSUB_OVF_EN
        check({tag, " ovf"}, m_ovf, exp_ovf);
`endif
    endtask

    task automatic idle_gap(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check("hold done", m_done, 1'b0);
            check("hold result", m_res, exp_res);
            check("hold cout", m_cout, exp_cout);
        end
    endtask

    initial begin
        logic [15:0] mask, ra, rb;
        int          cyc;
        logic        any_done;

        rst = 1'b1; start = 1'b0; sel = 0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset busy", {busy0, busy1, busy2}, 3'b000);
        check("reset done", {done0, done1, done2}, 3'b000);
        check("reset result", {res0, res1, res2}, 32'h0);
        check("reset cout", {cout0, cout1, cout2}, 3'b000);
        check("reset ovf", {ovf0, ovf1, ovf2}, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 1'b1, 16'h05, 16'h03, 1'b0, 1'b0, "sub 05-03");
        idle_gap(2);
        run_op(0, 1'b1, 16'h00, 16'h01, 1'b1, 1'b0, "sub 00-01-1");
        idle_gap(1);
        run_op(0, 1'b0, 16'h7F, 16'h01, 1'b0, 1'b0, "add 7F+01");
        idle_gap(1);
        run_op(0, 1'b0, 16'hFF, 16'h01, 1'b0, 1'b0, "add FF+01");
        run_op(0, 1'b0, 16'h10, 16'h01, 1'b0, 1'b0, "b2b add 10+01");
        idle_gap(1);
        run_op(1, 1'b1, 16'h1234, 16'h0235, 1'b0, 1'b1, "w16 sub disturbed");
        idle_gap(1);
        run_op(2, 1'b0, 16'h80, 16'h80, 1'b1, 1'b0, "n1 add 80+80+1");
        idle_gap(1);

        for (int i = 0; i < 90; i++) begin
            int s_sel;
            s_sel = i % 3;
            mask  = (width_of(s_sel) == 16) ? 16'hFFFF : 16'h00FF;
            ra    = 16'($urandom) & mask;
            rb    = 16'($urandom) & mask;
            run_op(s_sel, 1'($urandom), ra, rb, 1'($urandom), 1'($urandom % 4 == 0), "rand");
            idle_gap(int'($urandom_range(0, 2)));
        end

        // Reset during the 4th RUN cycle drops the operation.
        sel = 0; sub = 1'b0; a = 16'h33; b = 16'h44; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun rst busy", busy0, 1'b0);
        check("midrun rst done", done0, 1'b0);
        check("midrun rst result", res0, 8'h00);
        check("midrun rst cout", cout0, 1'b0);
        check("midrun rst ovf", ovf0, 1'b0);
        any_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            any_done |= done0 | busy0;
        end
        check("midrun rst no activity", any_done, 1'b0);
        run_op(0, 1'b1, 16'h40, 16'h41, 1'b0, 1'b0, "after rst");
        idle_gap(1);

        // Reset and start on the same edge: start is dropped.
        sel = 0; rst = 1'b1; start = 1'b1; a = 16'h01; b = 16'h01;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", busy0, 1'b0);
        cyc = 0;
        any_done = 1'b0;
        while (cyc < 12) begin
            @(negedge clk);
            any_done |= done0 | busy0;
            cyc++;
        end
        check("rst+start no activity", any_done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
